// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: FETCH -> WAIT -> EXEC.
// Optional PC_FETCH_MISALIGN_CHECK_EN adds misalign_err and a halt state on misaligned targets.
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic [1:0]      next_pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc_imm_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            ex_done,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  output logic            misalign_err,
`endif
  output logic            instr_valid
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign func3     = instr[14:12];
  assign func7     = instr[30];

  // Raw next-PC target before any alignment handling.
  always_comb begin
    target = pc_plus4;
    case (next_pc_sel)
      2'b01:   if (branch_taken) target = pc_imm_target;
      2'b10:   target = pc_imm_target;
      2'b11:   target = jalr_target & ~XLEN'(1);
      default: target = pc_plus4;
    endcase
  end

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  assign misalign = |target[1:0];
  assign next_pc  = target;
`else
  assign misalign = 1'b0;
  assign next_pc  = target & ~XLEN'(3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_next = S_EXEC;
      S_EXEC: begin
        if (ex_done) begin
`ifdef PC_FETCH_MISALIGN_CHECK_EN
          state_next = misalign ? S_HALT : S_FETCH;
`else
          state_next = S_FETCH;
`endif
        end
      end
`ifdef PC_FETCH_MISALIGN_CHECK_EN
      S_HALT:  state_next = S_HALT;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Request is gated by rst_n so it stays low while reset holds the FSM in FETCH.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_FETCH: imem_req    = rst_n;
      S_EXEC:  instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
    end else begin
      if (state == S_WAIT && imem_rvalid) instr <= imem_rdata;
      if (state == S_EXEC && ex_done && !misalign) pc <= next_pc;
    end
  end

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  misalign_err <= 1'b0;
    else if (state == S_EXEC && ex_done && misalign) misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; define PC_FETCH_MISALIGN_CHECK_EN to cover the halt path.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  next_pc_sel;
  logic        branch_taken;
  logic [31:0] pc_imm_target;
  logic [31:0] jalr_target;
  logic        ex_done;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        instr_valid;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .next_pc_sel(next_pc_sel), .branch_taken(branch_taken),
    .pc_imm_target(pc_imm_target), .jalr_target(jalr_target),
    .ex_done(ex_done), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7),
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, returns its address, then answers one cycle later.
  task automatic serve_fetch(input logic [31:0] data, output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = 32'hx;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok   = 1'b1;
        addr = imem_addr;
        break;
      end
      tick();
    end
    if (ok) begin
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
      imem_rvalid = 1'b0;
    end
  endtask

  task automatic exec_step(input logic [1:0] sel, input logic bt,
                           input logic [31:0] imm, input logic [31:0] jt);
    next_pc_sel   = sel;
    branch_taken  = bt;
    pc_imm_target = imm;
    jalr_target   = jt;
    ex_done       = 1'b1;
    tick();
    ex_done       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_clk: got %b expected 0", imem_req); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_first_fetch();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b expected 0", instr_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    ex_done     = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    ex_done     = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL exec_valid: got %b expected 1", instr_valid); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL instr: got %h expected 00500093", instr); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL opcode: got %h expected 13", opcode); end
    checks++; if (func3 !== 3'd0) begin errors++; $display("FAIL func3: got %0d expected 0", func3); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL pc_plus4_0: got %h expected 00000004", pc_plus4); end
    tick();
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL exec_hold: got valid=%b req=%b expected valid=1 req=0", instr_valid, imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    bit ok;
    for (int k = 1; k <= 3; k++) begin
      exec_step(2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_latency%0d: got %b expected 1", k, imem_req); end
      serve_fetch(32'h0000_0013, a, ok);
      checks++; if (!ok || a !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d: got %h ok=%0d expected %h", k, a, ok, 32'(4 * k)); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok;
    exec_step(2'b10, 1'b0, 32'h20, 32'h0);
    serve_fetch(32'h00c5_a023, a, ok);
    checks++; if (!ok || a !== 32'h20) begin errors++; $display("FAIL jal_addr: got %h expected 00000020", a); end
    checks++; if (opcode !== 7'h23 || func3 !== 3'd2) begin errors++; $display("FAIL sw_fields: got op=%h f3=%0d expected op=23 f3=2", opcode, func3); end
    exec_step(2'b01, 1'b0, 32'h80, 32'h0);
    serve_fetch(32'h0000_0013, a, ok);
    checks++; if (!ok || a !== 32'h24) begin errors++; $display("FAIL br_not_taken: got %h expected 00000024", a); end
    exec_step(2'b01, 1'b1, 32'h80, 32'h0);
    serve_fetch(32'h4020_8033, a, ok);
    checks++; if (!ok || a !== 32'h80) begin errors++; $display("FAIL br_taken: got %h expected 00000080", a); end
  endtask

  task automatic test_jalr_and_hold();
    logic [31:0] a;
    bit ok;
    checks++; if (pc_plus4 !== 32'h84) begin errors++; $display("FAIL link_value: got %h expected 00000084", pc_plus4); end
    checks++; if (func7 !== 1'b1 || opcode !== 7'h33) begin errors++; $display("FAIL sub_fields: got f7=%b op=%h expected f7=1 op=33", func7, opcode); end
    exec_step(2'b11, 1'b0, 32'h0, 32'h1001);
    serve_fetch(32'h1111_1113, a, ok);
    checks++; if (!ok || a !== 32'h1000) begin errors++; $display("FAIL jalr_addr: got %h expected 00001000", a); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    imem_rvalid = 1'b0;
    checks++; if (instr !== 32'h1111_1113) begin errors++; $display("FAIL exec_rvalid_ignored: got %h expected 11111113", instr); end
    checks++; if (pc !== 32'h1000 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL exec_stall: got pc=%h valid=%b req=%b expected pc=00001000 valid=1 req=0", pc, instr_valid, imem_req); end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit ok;
    exec_step(2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    serve_fetch(32'h0000_0013, a, ok);
    checks++; if (!ok || a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_addr: got %h expected fffffffc", a); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4); end
    exec_step(2'b00, 1'b0, 32'h0, 32'h0);
    serve_fetch(32'h0000_0013, a, ok);
    checks++; if (!ok || a !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", a); end
  endtask

`ifndef PC_FETCH_MISALIGN_CHECK_EN
  task automatic test_align_mask();
    logic [31:0] a;
    bit ok;
    exec_step(2'b10, 1'b0, 32'h102, 32'h0);
    serve_fetch(32'h0000_0013, a, ok);
    checks++; if (!ok || a !== 32'h100) begin errors++; $display("FAIL align_mask: got %h expected 00000100", a); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    exec_step(2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0 || instr !== 32'h13) begin errors++; $display("FAIL async_reset: got addr=%h instr=%h expected 00000000/00000013", imem_addr, instr); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL refetch: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin errors++; $display("FAIL late_rvalid: got valid=%b instr=%h expected valid=0 instr=00000013", instr_valid, instr); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL refetch_exec: got %b expected 1", instr_valid); end
  endtask

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int reqs = 0;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_idle: got %b expected 0", misalign_err); end
    exec_step(2'b10, 1'b0, 32'h102, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
    checks++; if (pc !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_halt: got pc=%h valid=%b expected pc=00000000 valid=0", pc, instr_valid); end
    for (int i = 0; i < 6; i++) begin
      if (imem_req) reqs++;
      tick();
    end
    checks++; if (reqs != 0) begin errors++; $display("FAIL misalign_no_fetch: got %0d requests expected 0", reqs); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; next_pc_sel = 2'b00;
    branch_taken = 1'b0; pc_imm_target = '0; jalr_target = '0; ex_done = 1'b0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_jalr_and_hold();
    test_wrap();
`ifndef PC_FETCH_MISALIGN_CHECK_EN
    test_align_mask();
`endif
    test_reset_mid_wait();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter XLEN, default 32, the PC and instruction width.
REQ-003 Clock and reset are fixed: one clock; reset is asynchronous and active-low. Ports below, clock and reset first.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  XLEN  fetch address.
REQ-008 imem_rvalid  in  1  instruction data valid.
REQ-009 imem_rdata  in  XLEN  fetched instruction.
REQ-010 next_pc_sel  in  2  00=PC+4, 01=branch, 10=jal, 11=jalr.
REQ-011 branch_taken  in  1  branch comparator result.
REQ-012 pc_imm_target  in  XLEN  PC+immediate (branch/jal target).
REQ-013 jalr_target  in  XLEN  rs1+immediate from ALU.
REQ-014 ex_done  in  1  core has consumed the current instruction; next-PC inputs are valid.
REQ-015 pc  out  XLEN  PC of held instruction.
REQ-016 pc_plus4  out  XLEN  pc+4, link value.
REQ-017 instr  out  XLEN  held instruction register.
REQ-018 opcode  out  7  instr[6:0] to decoder.
REQ-019 func3  out  3  instr[14:12].
REQ-020 func7  out  1  instr[30].
REQ-021 instr_valid  out  1  instr/fields valid for decode.

Function
REQ-022 FSM states: FETCH, WAIT, EXEC.
REQ-023 FETCH: imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-024 WAIT: imem_req=0; on imem_rvalid, latch imem_rdata into instr and go to EXEC. Otherwise stay in WAIT indefinitely.
REQ-025 imem_rvalid in FETCH or EXEC is ignored.
REQ-026 EXEC: instr_valid=1. On ex_done, load pc with the next PC and go to FETCH. Otherwise hold all outputs.
REQ-027 Next PC selection:
- 00: pc+4.
- 01: pc_imm_target if branch_taken, else pc+4.
- 10: pc_imm_target.
- 11: {jalr_target[XLEN-1:1],1'b0}.
REQ-028 All additions are modulo 2^XLEN; pc=32'hFFFF_FFFC with sel 00 wraps to 0.
REQ-029 opcode/func3/func7 are combinational slices of instr; pc_plus4 is combinational pc+4.
REQ-030 Latency: request to instr_valid is 2 cycles plus memory wait; ex_done to next imem_req is 1 cycle.
REQ-031 ex_done outside EXEC is ignored.

Reset
REQ-032 While rst_n=0, regardless of clk:
- pc=RESET_PC.
- instr=32'h0000_0013 (NOP).
- state=FETCH.
- imem_req=0, instr_valid=0.
REQ-033 The first imem_req is asserted in the first cycle after rst_n deasserts.
REQ-034 Reset asserted during WAIT abandons the fetch; a late imem_rvalid in FETCH is ignored.

Configuration
REQ-035 Macro PC_FETCH_MISALIGN_CHECK_EN, when defined, adds output misalign_err (1 bit).
- misalign_err is set in EXEC on ex_done if the selected target[1:0]!=0.
- When set, pc is not updated and the FSM goes to EXEC-halt: instr_valid=0 and no further fetch until reset.
- misalign_err resets to 0.
REQ-036 Without the macro, the misalign_err port does not exist, and targets are used with bits [1:0] forced to 0 (jalr additionally forces bit 0).

Verification
REQ-037 Reset release, memory returns 32'h00500093 one cycle after the request -> imem_addr=0; instr_valid high 2 cycles after imem_req; opcode=7'h13, func3=0.
REQ-038 Sequential ex_done x3 with sel=00 -> imem_addr sequence 0, 4, 8, C.
REQ-039 pc=0x20, sel=01, branch_taken=0, pc_imm_target=0x80 -> next fetch 0x24; with branch_taken=1 -> next fetch 0x80.
REQ-040 sel=11, jalr_target=0x1001 -> next fetch 0x1000; pc_plus4 = old pc+4 during EXEC.
REQ-041 rst_n pulsed low mid-WAIT, then imem_rvalid -> instr_valid stays 0; next imem_addr=RESET_PC.
REQ-042 With PC_FETCH_MISALIGN_CHECK_EN, sel=10, pc_imm_target=0x102 -> misalign_err=1; pc unchanged; no further imem_req.
